// File: rtl/bit_count_sequencer_pkg.sv
// Shared definitions for the multi-cycle CLZ/CLO unit: bus widths, function codes, FSM states.
// Pure declarations; no logic or timing of its own.
package bit_count_sequencer_pkg;

  localparam int DATA_BUS  = 32;
  localparam int FUNCT_BUS = 6;

  localparam logic [FUNCT_BUS-1:0] FUNCT2_CLZ = 6'b100000;
  localparam logic [FUNCT_BUS-1:0] FUNCT2_CLO = 6'b100001;

  typedef enum logic [1:0] {
    BCS_IDLE = 2'd0,
    BCS_SCAN = 2'd1,
    BCS_DONE = 2'd2
  } bcs_state_t;

  function automatic logic is_count_funct(input logic [FUNCT_BUS-1:0] f);
    return (f == FUNCT2_CLZ) || (f == FUNCT2_CLO);
  endfunction

endpackage

// File: rtl/bit_count_sequencer_chunk_lzc.sv
// Combinational leading-zero counter for one chunk; zero latency, no flow control.
// An all-zero chunk reports WIDTH.
module chunk_lzc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]       chunk,
  output logic [$clog2(WIDTH):0] count
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Walk LSB to MSB so the highest set bit is the last one to write count.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (chunk[i]) begin
        count = CW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/bit_count_sequencer.sv
// Multi-cycle CLZ/CLO: one chunk per cycle from the MSB end, done at accept+1+chunks_scanned.
// Holds the pipeline through stall_req while busy; flush or rst aborts without a done pulse.
module bit_count_sequencer
  import bit_count_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_BUS,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic [FUNCT_BUS-1:0]  funct,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic                  stall_req,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int CNT_W      = $clog2(DATA_WIDTH) + 1;
  localparam int LZ_W       = $clog2(CHUNK_WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  bcs_state_t state, state_nxt;
  logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0] work, work_nxt;
  logic [IDX_W-1:0]      index, index_nxt;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [DATA_WIDTH-1:0] result_q, result_nxt;

  logic                   accept;
  logic [CHUNK_WIDTH-1:0] chunk;
  logic [LZ_W-1:0]        chunk_lz;

  assign accept = (state == BCS_IDLE) && start && !flush && !rst && is_count_funct(funct);
  assign chunk  = work[index];

  chunk_lzc #(
    .WIDTH (CHUNK_WIDTH)
  ) u_chunk_lzc (
    .chunk (chunk),
    .count (chunk_lz)
  );

  always_comb begin
    state_nxt  = state;
    work_nxt   = work;
    index_nxt  = index;
    count_nxt  = count;
    result_nxt = result_q;
    case (state)
      BCS_IDLE: begin
        if (accept) begin
          work_nxt  = (funct == FUNCT2_CLO) ? ~operand : operand;
          index_nxt = LAST_IDX;
          count_nxt = '0;
          state_nxt = BCS_SCAN;
        end
      end
      BCS_SCAN: begin
        if (chunk != '0) begin
          count_nxt = count + CNT_W'(chunk_lz);
          state_nxt = BCS_DONE;
        end else if (index == '0) begin
          count_nxt = count + CNT_W'(CHUNK_WIDTH);
          state_nxt = BCS_DONE;
        end else begin
          count_nxt = count + CNT_W'(CHUNK_WIDTH);
          index_nxt = index - IDX_W'(1);
        end
      end
      BCS_DONE: begin
        result_nxt = DATA_WIDTH'(count);
        state_nxt  = BCS_IDLE;
      end
      default: state_nxt = BCS_IDLE;
    endcase
    // An aborted DONE cycle must not publish its count.
    if (flush) begin
      state_nxt  = BCS_IDLE;
      result_nxt = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BCS_IDLE;
      work     <= '0;
      index    <= LAST_IDX;
      count    <= '0;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      work     <= work_nxt;
      index    <= index_nxt;
      count    <= count_nxt;
      result_q <= result_nxt;
    end
  end

  assign done      = (state == BCS_DONE) && !flush && !rst;
  assign result    = done ? DATA_WIDTH'(count) : result_q;
  assign stall_req = !flush && !rst && ((state == BCS_SCAN) || accept);

endmodule

// File: tb/tb_bit_count_sequencer.sv
// Directed bench for bit_count_sequencer: exact-cycle latency, stall, flush and reset behaviour.
module tb_bit_count_sequencer;
  import bit_count_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] operand;
  logic        stall_req;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  bit_count_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .funct     (funct),
    .operand   (operand),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an op at the current cycle, hold start through DONE, check per-cycle outputs.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] op,
                        input logic [31:0] exp_res, input int k);
    start = 1'b1; funct = f; operand = op;
    #1;
    check({tag, " accept stall"}, 32'(stall_req), 32'd1);
    check({tag, " accept done"}, 32'(done), 32'd0);
    for (int c = 1; c <= k; c++) begin
      step();
      operand = 32'hDEAD_BEEF;
      #1;
      check({tag, " scan stall"}, 32'(stall_req), 32'd1);
      check({tag, " scan done"}, 32'(done), 32'd0);
    end
    step();
    check({tag, " done pulse"}, 32'(done), 32'd1);
    check({tag, " done stall"}, 32'(stall_req), 32'd0);
    check({tag, " result"}, result, exp_res);
    start = 1'b0;
    step();
    check({tag, " post done"}, 32'(done), 32'd0);
    check({tag, " post stall"}, 32'(stall_req), 32'd0);
    check({tag, " result held"}, result, exp_res);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; start = 1'b0; funct = '0; operand = '0;
    step();
    step();
    check("reset stall", 32'(stall_req), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;
    step();

    run_op("clz msb", FUNCT2_CLZ, 32'h8000_0000, 32'd0, 1);
    run_op("clz one", FUNCT2_CLZ, 32'h0000_0001, 32'd31, 4);
    run_op("clz zero", FUNCT2_CLZ, 32'h0000_0000, 32'd32, 4);
    run_op("clo fff", FUNCT2_CLO, 32'hFFF0_0000, 32'd12, 2);
    run_op("clo ones", FUNCT2_CLO, 32'hFFFF_FFFF, 32'd32, 4);

    // Flush two cycles after accept, while still scanning.
    start = 1'b1; funct = FUNCT2_CLZ; operand = 32'h0000_0100;
    step();
    step();
    flush = 1'b1;
    #1;
    check("flush stall", 32'(stall_req), 32'd0);
    check("flush done", 32'(done), 32'd0);
    step();
    flush = 1'b0; start = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("flush no done", 32'(done), 32'd0);
      check("flush idle stall", 32'(stall_req), 32'd0);
      step();
    end
    check("flush result kept", result, 32'd32);

    // Unsupported function code is ignored.
    start = 1'b1; funct = 6'b000000; operand = 32'h0000_0001;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("bad funct stall", 32'(stall_req), 32'd0);
      check("bad funct done", 32'(done), 32'd0);
      step();
    end
    check("bad funct result", result, 32'd32);
    run_op("clz 00ff", FUNCT2_CLZ, 32'h00FF_0000, 32'd8, 2);
    run_op("clz 1000", FUNCT2_CLZ, 32'h0000_1000, 32'd19, 3);
    run_op("clo fffe", FUNCT2_CLO, 32'hFFFF_FFFE, 32'd31, 4);

    // Flush and accept in the same cycle: flush wins.
    start = 1'b1; funct = FUNCT2_CLZ; operand = 32'h8000_0000; flush = 1'b1;
    #1;
    check("flush+start stall", 32'(stall_req), 32'd0);
    step();
    flush = 1'b0; start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("flush+start no done", 32'(done), 32'd0);
      check("flush+start no stall", 32'(stall_req), 32'd0);
      step();
    end
    check("flush+start result", result, 32'd31);

    // Flush landing on the DONE cycle suppresses the pulse and keeps the old result.
    start = 1'b1; funct = FUNCT2_CLZ; operand = 32'h0100_0000;
    step();
    step();
    flush = 1'b1;
    #1;
    check("flush in done pulse", 32'(done), 32'd0);
    check("flush in done result", result, 32'd31);
    step();
    flush = 1'b0; start = 1'b0;
    #1;
    check("after done flush", 32'(done), 32'd0);
    check("after done flush result", result, 32'd31);
    step();

    // Reset while scanning.
    start = 1'b1; funct = FUNCT2_CLZ; operand = 32'h0000_0001;
    step();
    rst = 1'b1;
    #1;
    check("rst scan stall", 32'(stall_req), 32'd0);
    check("rst scan done", 32'(done), 32'd0);
    step();
    rst = 1'b0; start = 1'b0;
    #1;
    check("post rst stall", 32'(stall_req), 32'd0);
    check("post rst done", 32'(done), 32'd0);
    check("post rst result", result, 32'd0);
    step();
    check("post rst idle", 32'(done), 32'd0);
    run_op("clo 7fff", FUNCT2_CLO, 32'h7FFF_FFFF, 32'd0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
